div_seq: RTL
============

Name: div_seq

Overview:
- Iterative 32-bit integer divider and its sequencer, sitting beside the execute stage.
- Consumes the execute stage's div_enable, sign and operand outputs and returns div_complete plus quotient and remainder.
- Serves one division at a time, holds the result until the execute stage hands the instruction to memory stage, and aborts cleanly on any pipeline flush.

Parameters:
DATA_W, 32, operand/result width
ITER_W, 6, iteration counter width (must hold DATA_W)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
div_enable  input  1  level request from execute stage, high while a div/mod instruction is valid in EX
div_sign  input  1  1 = signed division, 0 = unsigned
div_rj  input  DATA_W  dividend
div_rkd  input  DATA_W  divisor
div_taken  input  1  EX-to-MS handshake fired this cycle (es_to_ms_valid && ms_allowin)
flush  input  1  OR of excp/ertn/refetch/icacop/idle flush
div_complete  output  1  result valid; execute stage may advance
div_busy  output  1  state != IDLE
div_quot  output  DATA_W  quotient
div_rem  output  DATA_W  remainder

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, div_complete=0, div_busy=0, div_quot=0, div_rem=0.
- States: IDLE, PREP, BUSY, FIX, DONE.
- IDLE -> PREP when div_enable=1 && flush=0. Operands and sign are latched on this edge. Later changes on div_rj/div_rkd are ignored until the next request.
- PREP (1 cycle):
  - Form |dividend| and |divisor| when div_sign=1; raw values otherwise.
  - Record quotient sign = sign(rj) XOR sign(rkd); remainder sign = sign(rj).
  - Flag divisor-zero and signed overflow (rj=0x80000000, rkd=0xFFFFFFFF).
  - Load counter=DATA_W and clear partial remainder.
- BUSY: one restoring step per cycle, with a 33-bit partial remainder.
  - Shift in the next dividend MSB.
  - Subtract the divisor; if non-negative, keep the difference and set the quotient bit to 1.
  - Counter decrements; at counter=1 -> FIX. BUSY lasts exactly DATA_W cycles.
- FIX (1 cycle): apply sign correction, then load div_quot/div_rem.
  - Divisor zero, either signedness: quot=0xFFFFFFFF, rem=rj.
  - Signed overflow: quot=0x80000000, rem=0.
  - Otherwise: quotient negated if quotient sign=1; remainder negated if remainder sign=1.
- DONE: div_complete=1, registered, stable.
  - div_taken=1 -> IDLE next cycle, with div_complete=0 next cycle. No same-edge restart.
  - Back-to-back divides need one IDLE bubble, so the next request is re-sampled in IDLE.
  - div_enable dropping without div_taken while in DONE: remain in DONE (cannot happen except via flush).
- Latency: request sampled at edge 0 -> div_complete high after edge DATA_W+3 (35 cycles at DATA_W=32).
- flush=1 in any state: next state IDLE, div_complete=0; outputs div_quot/div_rem keep their last values. flush has priority over a new request and over div_taken.
- flush and div_enable in the same IDLE cycle: request ignored.
- div_busy is combinational from state.

Optional Feature:
DIV_SEQ_EARLY_OUT_EN
- Defined: PREP goes directly to FIX, skipping BUSY, when the divisor is zero, on signed overflow, or when |dividend| < |divisor| (result quot=0, rem=rj). Latency for these cases is 3 cycles.
- Not defined: every request spends DATA_W cycles in BUSY.
- Results are bit-identical in both builds.

Decomposition:
- Shared package div_seq_pkg: state enum (IDLE/PREP/BUSY/FIX/DONE), DIV_LAT=DATA_W+3, and the constants DIV0_QUOT=0xFFFFFFFF, OVF_QUOT=0x80000000.
- One natural sub-module, div_step: combinational single restoring iteration. Inputs are partial remainder, divisor and dividend bit; outputs are the next remainder and the quotient bit. The sequencer instantiates it once.

Test Plan:
- Unsigned 100/7, div_taken at the first complete cycle: div_complete rises 35 cycles after the request; quot=14, rem=2; div_complete low the following cycle.
- Signed 0xFFFFFFF9/2 (-7/2): quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF: quot=0x80000000, rem=0.
- Divide by zero, signed and unsigned, rj=0x12345678: quot=0xFFFFFFFF, rem=0x12345678. With DIV_SEQ_EARLY_OUT_EN, complete after 3 cycles.
- flush pulsed 10 cycles into BUSY: div_busy=0 next cycle, no div_complete. A new 9/3 request is then accepted and returns quot=3, rem=0 at 35 cycles.
- div_taken held low 4 cycles in DONE: div_complete and results stay stable. Second divide issued back-to-back gets a one-cycle IDLE gap, then completes correctly.
- reset asserted asynchronously mid-BUSY: all outputs 0 immediately, state IDLE; after release a new request behaves normally.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divider sequencer.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_LAT    = DIV_DATA_W + 3;

  localparam logic [DIV_DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [DIV_DATA_W-1:0] OVF_QUOT  = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_BUSY = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] dsr_i,
  input  logic              dvd_bit_i,
  output logic [DATA_W:0]   rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shf_s;
  logic [DATA_W:0] dsr_ext_s;
  logic [DATA_W:0] diff_s;

  always_comb begin
    shf_s     = {rem_i[DATA_W-1:0], dvd_bit_i};
    dsr_ext_s = {1'b0, dsr_i};
    diff_s    = shf_s - dsr_ext_s;
    q_bit_o   = (shf_s >= dsr_ext_s);
    rem_o     = q_bit_o ? diff_s : shf_s;
  end

endmodule

// File: rtl/div_seq.sv
// Sequenced 32-bit divider beside EX: IDLE/PREP/BUSY/FIX/DONE, flush-abortable.
// Optional build macro DIV_SEQ_EARLY_OUT_EN lets PREP skip BUSY for trivial results.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_enable,
  input  logic              div_sign,
  input  logic [DATA_W-1:0] div_rj,
  input  logic [DATA_W-1:0] div_rkd,
  input  logic              div_taken,
  input  logic              flush,
  output logic              div_complete,
  output logic              div_busy,
  output logic [DATA_W-1:0] div_quot,
  output logic [DATA_W-1:0] div_rem
);

  function automatic logic [DATA_W-1:0] abs_val(input logic en, input logic [DATA_W-1:0] v);
    return (en && v[DATA_W-1]) ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  state_e            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rj_q, rj_d, rkd_q, rkd_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dsr_q, dsr_d;
  logic [DATA_W:0]   prem_q, prem_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;
  logic [DATA_W-1:0] quot_q, quot_d, rem_q, rem_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] abs_rj_s, abs_rkd_s;
  logic              dz_s, ovf_s;
  logic [DATA_W:0]   step_rem_s;
  logic              step_q_s;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (prem_q),
    .dsr_i     (dsr_q),
    .dvd_bit_i (dvd_q[DATA_W-1]),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_q_s)
  );

  always_comb begin
    abs_rj_s  = abs_val(sign_q, rj_q);
    abs_rkd_s = abs_val(sign_q, rkd_q);
    dz_s      = (rkd_q == {DATA_W{1'b0}});
    ovf_s     = sign_q && (rj_q == OVF_QUOT) && (rkd_q == {DATA_W{1'b1}});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rj_d    = rj_q;
    rkd_d   = rkd_q;
    sign_d  = sign_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_enable) begin
          state_d = S_PREP;
          rj_d    = div_rj;
          rkd_d   = div_rkd;
          sign_d  = div_sign;
        end
      end
      S_PREP: begin
        dvd_d   = abs_rj_s;
        dsr_d   = abs_rkd_s;
        prem_d  = {(DATA_W+1){1'b0}};
        cnt_d   = ITER_W'(DATA_W);
        qneg_d  = sign_q && (rj_q[DATA_W-1] ^ rkd_q[DATA_W-1]);
        rneg_d  = sign_q && rj_q[DATA_W-1];
        dz_d    = dz_s;
        ovf_d   = ovf_s;
        state_d = S_BUSY;
`ifdef DIV_SEQ_EARLY_OUT_EN
        // Small dividend: preload quotient 0 and remainder |rj| so FIX's sign fix yields rem=rj.
        if (dz_s || ovf_s || (abs_rj_s < abs_rkd_s)) begin
          state_d = S_FIX;
          dvd_d   = {DATA_W{1'b0}};
          prem_d  = {1'b0, abs_rj_s};
        end
`endif
      end
      S_BUSY: begin
        prem_d = step_rem_s;
        dvd_d  = {dvd_q[DATA_W-2:0], step_q_s};
        cnt_d  = cnt_q - {{(ITER_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(ITER_W-1){1'b0}}, 1'b1}) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          quot_d = DIV0_QUOT;
          rem_d  = rj_q;
        end else if (ovf_q) begin
          quot_d = OVF_QUOT;
          rem_d  = {DATA_W{1'b0}};
        end else begin
          quot_d = qneg_q ? ({DATA_W{1'b0}} - dvd_q) : dvd_q;
          rem_d  = rneg_q ? ({DATA_W{1'b0}} - prem_q[DATA_W-1:0]) : prem_q[DATA_W-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (div_taken) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush wins over everything and leaves the visible results untouched.
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {ITER_W{1'b0}};
      rj_q    <= {DATA_W{1'b0}};
      rkd_q   <= {DATA_W{1'b0}};
      sign_q  <= 1'b0;
      dvd_q   <= {DATA_W{1'b0}};
      dsr_q   <= {DATA_W{1'b0}};
      prem_q  <= {(DATA_W+1){1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= {DATA_W{1'b0}};
      rem_q   <= {DATA_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rj_q    <= rj_d;
      rkd_q   <= rkd_d;
      sign_q  <= sign_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign div_complete = done_q;
  assign div_busy     = (state_q != S_IDLE);
  assign div_quot     = quot_q;
  assign div_rem      = rem_q;

endmodule
